// File: rtl/lt24_pkg.sv
// Shared command codes and decoder state encoding for the LT24 write-bus decoder.
package lt24_pkg;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        COL_PARAM,
        PAGE_PARAM,
        MEM_WRITE,
        OTHER_PARAM
    } lt24_state_t;
endpackage

// File: rtl/lt24_bus_sync.sv
// Two-flop synchroniser for the LT24 bus plus write-edge and read/collision error detection.
module lt24_bus_sync (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_cs_n,
    input  logic        i_wr_n,
    input  logic        i_rd_n,
    input  logic        i_rs,
    input  logic [15:0] i_data,
    output logic        o_wrEvent,
    output logic        o_rdError,
    output logic        o_rsS,
    output logic [15:0] o_dataS
);
    import lt24_pkg::*;

    // Stage [2] holds the sample taken one clock before stage [1]; a write
    // completes when [1] sees Wr_n high and [2] still holds the low sample.
    logic [2:0]       r_cs, r_wr, r_rs;
    logic [1:0]       r_rd;
    logic [2:0][15:0] r_data;
    logic             r_errCond, r_collide;
    logic             r_wrEvent, r_rdError, r_rsS;
    logic [15:0]      r_dataS;

    logic w_errCond, w_wrRise;

    assign w_errCond = ~r_rd[1] & (~r_cs[1] | ~r_wr[1]);
    assign w_wrRise  = r_wr[1] & ~r_wr[2] & ~r_cs[2] & ~r_collide;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cs      <= '1;
            r_wr      <= '1;
            r_rd      <= '1;
            r_rs      <= '0;
            r_data    <= '0;
            r_errCond <= 1'b0;
            r_collide <= 1'b0;
            r_wrEvent <= 1'b0;
            r_rdError <= 1'b0;
            r_rsS     <= 1'b0;
            r_dataS   <= '0;
        end else begin
            r_cs      <= i_clear ? 3'b111 : {r_cs[1:0], i_cs_n};
            r_wr      <= i_clear ? 3'b111 : {r_wr[1:0], i_wr_n};
            r_rd      <= i_clear ? 2'b11  : {r_rd[0], i_rd_n};
            r_rs      <= i_clear ? 3'b000 : {r_rs[1:0], i_rs};
            r_data    <= i_clear ? '0     : {r_data[1:0], i_data};
            r_errCond <= ~i_clear & w_errCond;
            r_rdError <= ~i_clear & w_errCond & ~r_errCond;
            // a write that saw Rd_n low at any point of its low phase is dropped
            r_collide <= ~i_clear & ((~r_wr[1] & ~r_rd[1]) | (r_collide & ~r_wr[1]));
            r_wrEvent <= ~i_clear & w_wrRise;
            r_rsS     <= ~i_clear & r_rs[2];
            r_dataS   <= i_clear ? '0 : r_data[2];
        end
    end

    assign o_wrEvent = r_wrEvent;
    assign o_rdError = r_rdError;
    assign o_rsS     = r_rsS;
    assign o_dataS   = r_dataS;
endmodule

// File: rtl/lt24_bus_decoder.sv
// LT24 write-bus decoder: command/parameter/pixel strobes with CASET/PASET window tracking.
module lt24_bus_decoder #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        LT24Reset_n,
    input  logic        LT24CS_n,
    input  logic        LT24Wr_n,
    input  logic        LT24Rd_n,
    input  logic        LT24RS,
    input  logic [15:0] LT24Data,
    output logic        cmdStrobe,
    output logic [7:0]  cmdCode,
    output logic        paramStrobe,
    output logic [7:0]  paramData,
    output logic        pixelWrite,
    output logic [7:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic [15:0] pixelData,
    output logic        displayOn,
    output logic        protocolError
);
    import lt24_pkg::*;

    localparam logic [7:0]  X_END = 8'(WIDTH - 1);
    localparam logic [8:0]  Y_END = 9'(HEIGHT - 1);
    localparam logic [15:0] X_LIM = 16'(WIDTH);
    localparam logic [15:0] Y_LIM = 16'(HEIGHT);

    logic        w_wrEvent, w_rdError, w_rsS;
    logic [15:0] w_dataS;

    lt24_bus_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (~LT24Reset_n),
        .i_cs_n    (LT24CS_n),
        .i_wr_n    (LT24Wr_n),
        .i_rd_n    (LT24Rd_n),
        .i_rs      (LT24RS),
        .i_data    (LT24Data),
        .o_wrEvent (w_wrEvent),
        .o_rdError (w_rdError),
        .o_rsS     (w_rsS),
        .o_dataS   (w_dataS)
    );

    lt24_state_t r_state;
    logic [7:0]  r_sc, r_ec, r_x;
    logic [8:0]  r_sp, r_ep, r_y;
    logic [7:0]  r_startHi, r_startLo, r_endHi;
    logic [2:0]  r_pcnt;
    logic        r_cmdStrobe, r_paramStrobe, r_pixelWrite, r_displayOn, r_protocolError;
    logic [7:0]  r_cmdCode, r_paramData;
    logic [15:0] r_pixelData;

    logic [15:0] w_start, w_end, w_lim;
    logic        w_winOk, w_swreset;

    assign w_start   = {r_startHi, r_startLo};
    assign w_end     = {r_endHi, w_dataS[7:0]};
    assign w_lim     = (r_state == COL_PARAM) ? X_LIM : Y_LIM;
    assign w_winOk   = (w_start <= w_end) && (w_end < w_lim);
    assign w_swreset = w_wrEvent & ~w_rsS & (w_dataS[7:0] == CMD_SWRESET);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_sc            <= '0;
            r_ec            <= X_END;
            r_sp            <= '0;
            r_ep            <= Y_END;
            r_x             <= '0;
            r_y             <= '0;
            r_startHi       <= '0;
            r_startLo       <= '0;
            r_endHi         <= '0;
            r_pcnt          <= '0;
            r_cmdStrobe     <= 1'b0;
            r_paramStrobe   <= 1'b0;
            r_pixelWrite    <= 1'b0;
            r_protocolError <= 1'b0;
            r_displayOn     <= 1'b0;
            r_cmdCode       <= '0;
            r_paramData     <= '0;
            r_pixelData     <= '0;
        end else begin
            r_cmdStrobe     <= 1'b0;
            r_paramStrobe   <= 1'b0;
            r_pixelWrite    <= 1'b0;
            r_protocolError <= LT24Reset_n & w_rdError;
            // display reset wins over any write completing in the same cycle
            if (!LT24Reset_n || w_swreset) begin
                r_state     <= IDLE;
                r_sc        <= '0;
                r_ec        <= X_END;
                r_sp        <= '0;
                r_ep        <= Y_END;
                r_x         <= '0;
                r_y         <= '0;
                r_startHi   <= '0;
                r_startLo   <= '0;
                r_endHi     <= '0;
                r_pcnt      <= '0;
                r_displayOn <= 1'b0;
                r_paramData <= '0;
                r_pixelData <= '0;
                r_cmdStrobe <= LT24Reset_n;
                r_cmdCode   <= LT24Reset_n ? CMD_SWRESET : 8'h00;
            end else if (w_wrEvent && !w_rsS) begin
                r_cmdStrobe <= 1'b1;
                r_cmdCode   <= w_dataS[7:0];
                r_pcnt      <= '0;
                case (w_dataS[7:0])
                    CMD_CASET:   r_state <= COL_PARAM;
                    CMD_PASET:   r_state <= PAGE_PARAM;
                    CMD_RAMWR: begin
                        r_state <= MEM_WRITE;
                        r_x     <= r_sc;
                        r_y     <= r_sp;
                    end
                    CMD_DISPOFF: begin
                        r_state     <= IDLE;
                        r_displayOn <= 1'b0;
                    end
                    CMD_DISPON: begin
                        r_state     <= IDLE;
                        r_displayOn <= 1'b1;
                    end
                    default:     r_state <= OTHER_PARAM;
                endcase
            end else if (w_wrEvent) begin
                case (r_state)
                    COL_PARAM, PAGE_PARAM: begin
                        r_paramStrobe <= 1'b1;
                        r_paramData   <= w_dataS[7:0];
                        if (r_pcnt != 3'd4) r_pcnt <= r_pcnt + 3'd1;
                        case (r_pcnt)
                            3'd0: r_startHi <= w_dataS[7:0];
                            3'd1: r_startLo <= w_dataS[7:0];
                            3'd2: r_endHi   <= w_dataS[7:0];
                            3'd3: begin
                                if (!w_winOk) begin
                                    r_protocolError <= 1'b1;
                                end else if (r_state == COL_PARAM) begin
                                    r_sc <= r_startLo;
                                    r_ec <= w_dataS[7:0];
                                end else begin
                                    r_sp <= w_start[8:0];
                                    r_ep <= w_end[8:0];
                                end
                            end
                            default: ;
                        endcase
                    end
                    MEM_WRITE: begin
                        r_pixelWrite <= 1'b1;
                        r_pixelData  <= w_dataS;
                        // pixelX/pixelY mirror r_x/r_y, so the advance lands after this pulse
                        if (r_x == r_ec) begin
                            r_x <= r_sc;
                            r_y <= (r_y == r_ep) ? r_sp : r_y + 9'd1;
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                    default: begin
                        r_paramStrobe <= 1'b1;
                        r_paramData   <= w_dataS[7:0];
                    end
                endcase
            end
        end
    end

    // Registered pixel position lags the counters by one write.
    logic [7:0] r_pixX;
    logic [8:0] r_pixY;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pixX <= '0;
            r_pixY <= '0;
        end else if (!LT24Reset_n || w_swreset) begin
            r_pixX <= '0;
            r_pixY <= '0;
        end else if (w_wrEvent && w_rsS && r_state == MEM_WRITE) begin
            r_pixX <= r_x;
            r_pixY <= r_y;
        end
    end

    assign cmdStrobe     = r_cmdStrobe;
    assign cmdCode       = r_cmdCode;
    assign paramStrobe   = r_paramStrobe;
    assign paramData     = r_paramData;
    assign pixelWrite    = r_pixelWrite;
    assign pixelX        = r_pixX;
    assign pixelY        = r_pixY;
    assign pixelData     = r_pixelData;
    assign displayOn     = r_displayOn;
    assign protocolError = r_protocolError;
endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Directed plus randomized bench for lt24_bus_decoder against a command-level display model.
module tb_lt24_bus_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        LT24Reset_n = 1'b1, LT24CS_n = 1'b1, LT24Wr_n = 1'b1, LT24Rd_n = 1'b1, LT24RS = 1'b0;
    logic [15:0] LT24Data = '0;
    logic        cmdStrobe, paramStrobe, pixelWrite, displayOn, protocolError;
    logic [7:0]  cmdCode, paramData, pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;

    lt24_bus_decoder dut (
        .clock(clock), .reset(reset), .LT24Reset_n(LT24Reset_n), .LT24CS_n(LT24CS_n),
        .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24RS(LT24RS), .LT24Data(LT24Data),
        .cmdStrobe(cmdStrobe), .cmdCode(cmdCode), .paramStrobe(paramStrobe), .paramData(paramData),
        .pixelWrite(pixelWrite), .pixelX(pixelX), .pixelY(pixelY), .pixelData(pixelData),
        .displayOn(displayOn), .protocolError(protocolError)
    );

    always #5 clock = ~clock;

    logic [3:0] w_strb;
    assign w_strb = {cmdStrobe, paramStrobe, pixelWrite, protocolError};

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Display model: last command, collected parameter bytes, window and cursor.
    int m_last, m_q[$], m_sc, m_ec, m_sp, m_ep, m_x, m_y;
    bit m_disp;
    logic [3:0]  e_vec;
    logic [7:0]  e_code, e_par, e_px;
    logic [8:0]  e_py;
    logic [15:0] e_pd;

    task automatic m_reset();
        m_disp = 0; m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
        m_x = 0; m_y = 0; m_last = -1; m_q.delete();
    endtask

    task automatic m_write(input logic rs, input logic [15:0] d);
        int s, e, lim;
        e_vec = 4'b0000;
        if (!rs) begin
            e_vec = 4'b1000; e_code = d[7:0]; m_q.delete();
            case (d[7:0])
                8'h01: m_reset();
                8'h28: begin m_disp = 0; m_last = -1; end
                8'h29: begin m_disp = 1; m_last = -1; end
                8'h2C: begin m_x = m_sc; m_y = m_sp; m_last = 'h2C; end
                default: m_last = int'(d[7:0]);
            endcase
        end else if (m_last == 'h2A || m_last == 'h2B) begin
            e_vec = 4'b0100; e_par = d[7:0];
            m_q.push_back(int'(d[7:0]));
            if (m_q.size() == 4) begin
                s = m_q[0] * 256 + m_q[1];
                e = m_q[2] * 256 + m_q[3];
                lim = (m_last == 'h2A) ? 240 : 320;
                if (s <= e && e < lim) begin
                    if (m_last == 'h2A) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else e_vec[0] = 1'b1;
            end
        end else if (m_last == 'h2C) begin
            e_vec = 4'b0010; e_px = 8'(m_x); e_py = 9'(m_y); e_pd = d;
            if (m_x == m_ec) begin
                m_x = m_sc;
                m_y = (m_y == m_ep) ? m_sp : m_y + 1;
            end else m_x = m_x + 1;
        end else begin
            e_vec = 4'b0100; e_par = d[7:0];
        end
    endtask

    // One bus write; strobe must appear exactly 3 clocks after Wr_n is first sampled high.
    task automatic bus_write(input logic rs, input logic [15:0] d, input int lo);
        m_write(rs, d);
        LT24RS = rs; LT24Data = d; LT24Wr_n = 1'b0;
        repeat (lo) @(negedge clock);
        LT24Wr_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("early_strobe", 64'(w_strb), 64'(0));
        @(negedge clock);
        chk("strobe", 64'(w_strb), 64'(e_vec));
        if (e_vec[3]) chk("cmdCode", 64'(cmdCode), 64'(e_code));
        if (e_vec[2]) chk("paramData", 64'(paramData), 64'(e_par));
        if (e_vec[1]) chk("pixel", 64'({pixelX, pixelY, pixelData}), 64'({e_px, e_py, e_pd}));
        @(negedge clock);
        chk("late_strobe", 64'(w_strb), 64'(0));
        chk("displayOn", 64'(displayOn), 64'(m_disp));
    endtask

    task automatic watch(input int cycles, output int n_err, output int n_oth);
        n_err = 0; n_oth = 0;
        repeat (cycles) begin
            @(negedge clock);
            n_err += int'(protocolError);
            n_oth += int'(cmdStrobe) + int'(paramStrobe) + int'(pixelWrite);
        end
    endtask

    initial begin
        int ne, no;
        int exp_xy [7][2] = '{'{10,5},'{11,5},'{12,5},'{10,6},'{11,6},'{12,6},'{10,5}};
        logic [7:0]  c;
        logic [15:0] d;
        m_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("rst_strobes", 64'(w_strb), 64'(0));
        chk("rst_codes", 64'({cmdCode, paramData, pixelData}), 64'(0));
        chk("rst_xy", 64'({pixelX, pixelY}), 64'(0));
        chk("rst_disp", 64'(displayOn), 64'(0));

        LT24CS_n = 1'b0;
        bus_write(1'b0, 16'h0029, 3);
        chk("dispon", 64'(displayOn), 64'(1));
        bus_write(1'b0, 16'h0028, 3);
        chk("dispoff", 64'(displayOn), 64'(0));

        foreach (exp_xy[i]) ;
        bus_write(1'b0, 16'h002A, 3);
        bus_write(1'b1, 16'h0000, 3); bus_write(1'b1, 16'h000A, 3);
        bus_write(1'b1, 16'h0000, 3); bus_write(1'b1, 16'h000C, 3);
        bus_write(1'b0, 16'h002B, 3);
        bus_write(1'b1, 16'h0000, 3); bus_write(1'b1, 16'h0005, 3);
        bus_write(1'b1, 16'h0000, 3); bus_write(1'b1, 16'h0006, 3);
        bus_write(1'b0, 16'h002C, 3);
        for (int i = 0; i < 7; i++) begin
            bus_write(1'b1, 16'hF800 + 16'(i), 3);
            chk("win_xy", 64'({pixelX, pixelY}), 64'({8'(exp_xy[i][0]), 9'(exp_xy[i][1])}));
        end

        bus_write(1'b0, 16'h002A, 3);
        bus_write(1'b1, 16'h0000, 2); bus_write(1'b1, 16'h0014, 2);
        bus_write(1'b1, 16'h0000, 2); bus_write(1'b1, 16'h000A, 2);
        bus_write(1'b0, 16'h002C, 2);
        bus_write(1'b1, 16'h1234, 2);
        chk("bad_win_xy", 64'({pixelX, pixelY}), 64'({8'd10, 9'd5}));

        LT24Rd_n = 1'b0;
        repeat (3) @(negedge clock);
        LT24Rd_n = 1'b1;
        watch(8, ne, no);
        chk("rd_err_cnt", 64'(ne), 64'(1));
        chk("rd_no_strobe", 64'(no), 64'(0));

        LT24RS = 1'b1; LT24Data = 16'hBEEF; LT24Wr_n = 1'b0; LT24Rd_n = 1'b0;
        repeat (3) @(negedge clock);
        LT24Wr_n = 1'b1; LT24Rd_n = 1'b1;
        watch(8, ne, no);
        chk("coll_err_cnt", 64'(ne), 64'(1));
        chk("coll_no_strobe", 64'(no), 64'(0));

        LT24CS_n = 1'b1; LT24RS = 1'b0; LT24Data = 16'h0029; LT24Wr_n = 1'b0;
        repeat (3) @(negedge clock);
        LT24Wr_n = 1'b1;
        watch(8, ne, no);
        LT24CS_n = 1'b0;
        chk("csh_no_strobe", 64'(ne + no), 64'(0));
        chk("csh_disp", 64'(displayOn), 64'(0));

        bus_write(1'b0, 16'h0029, 3);
        bus_write(1'b0, 16'h002C, 3);
        bus_write(1'b1, 16'h0101, 3);
        bus_write(1'b1, 16'h0202, 3);
        LT24RS = 1'b1; LT24Data = 16'h0303; LT24Wr_n = 1'b0;
        repeat (2) @(negedge clock);
        LT24Reset_n = 1'b0;
        watch(2, ne, no);
        LT24Wr_n = 1'b1;
        begin
            int ne2, no2;
            watch(4, ne2, no2);
            LT24Reset_n = 1'b1;
            ne += ne2; no += no2;
            watch(4, ne2, no2);
            ne += ne2; no += no2;
        end
        chk("hwrst_no_strobe", 64'(ne + no), 64'(0));
        chk("hwrst_disp", 64'(displayOn), 64'(0));
        m_reset();
        bus_write(1'b0, 16'h002C, 3);
        bus_write(1'b1, 16'h0404, 3);
        chk("hwrst_xy0", 64'({pixelX, pixelY}), 64'({8'd0, 9'd0}));
        bus_write(1'b1, 16'h0505, 3);
        chk("hwrst_xy1", 64'({pixelX, pixelY}), 64'({8'd1, 9'd0}));

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 7))
                    0: c = 8'h2A;
                    1: c = 8'h2B;
                    2: c = 8'h2C;
                    3: c = 8'h28;
                    4: c = 8'h29;
                    5: c = 8'h01;
                    default: c = 8'($urandom_range(0, 255));
                endcase
                bus_write(1'b0, {8'($urandom), c}, $urandom_range(2, 4));
            end else begin
                d = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: d[7:0] = 8'h00;
                    1: d[7:0] = 8'($urandom_range(0, 15));
                    default: ;
                endcase
                bus_write(1'b1, d, $urandom_range(2, 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
